// File: rtl/data_stack_if.sv
// Command/result bundle between the decoder/shifter side and the Forth parameter stack.
interface data_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
);
  logic [WIDTH-1:0] Result;
  logic [1:0]       stackCtrl;
  logic             clrFlags;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] N;
  logic [PTRW:0]    depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output Result, stackCtrl, clrFlags,
    input  T, N, depth, overflow, underflow
  );

  modport slave (
    input  Result, stackCtrl, clrFlags,
    output T, N, depth, overflow, underflow
  );
endinterface

// File: rtl/data_stack.sv
// Forth parameter stack: T and N in registers, deeper entries in a DEPTH-entry spill array.
// Optional feature macro DSTACK_GUARD_EN enables full/empty checking with sticky error flags.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
) (
  input  logic         clk,
  input  logic         rst,
  data_stack_if.slave  bus
);

  localparam logic [1:0] CMD_HOLD    = 2'b00;
  localparam logic [1:0] CMD_PUSH    = 2'b01;
  localparam logic [1:0] CMD_POP     = 2'b10;
  localparam logic [1:0] CMD_REPLACE = 2'b11;

  localparam logic [PTRW:0] DEPTH_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0] DEPTH_LAST = (PTRW+1)'(DEPTH - 1);
  localparam logic [PTRW:0] DEPTH_ONE  = (PTRW+1)'(1);

  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [PTRW:0]    depth_q, depth_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we_s;
  logic [PTRW-1:0]  free_idx_s;
  logic [PTRW-1:0]  top_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             ovf_set_s;
  logic             udf_set_s;

  // Slot indices wrap modulo DEPTH, so an empty stack's top index is DEPTH-1.
  assign free_idx_s = depth_q[PTRW-1:0];
  assign top_idx_s  = depth_q[PTRW-1:0] - {{(PTRW-1){1'b0}}, 1'b1};
  assign full_s     = (depth_q == DEPTH_FULL);
  assign empty_s    = (depth_q == {(PTRW+1){1'b0}});

  // Next-state decode for T, N, depth and the spill write enable.
  always_comb begin
    t_d       = t_q;
    n_d       = n_q;
    depth_d   = depth_q;
    mem_we_s  = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    case (bus.stackCtrl)
      CMD_HOLD: begin
        t_d = t_q;
      end
      CMD_PUSH: begin
`ifdef DSTACK_GUARD_EN
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          mem_we_s = 1'b1;
          n_d      = t_q;
          t_d      = bus.Result;
          depth_d  = depth_q + DEPTH_ONE;
        end
`else
        mem_we_s = 1'b1;
        n_d      = t_q;
        t_d      = bus.Result;
        if (full_s) begin
          depth_d = {(PTRW+1){1'b0}};
        end else begin
          depth_d = depth_q + DEPTH_ONE;
        end
`endif
      end
      CMD_POP: begin
`ifdef DSTACK_GUARD_EN
        if (empty_s) begin
          udf_set_s = 1'b1;
        end else begin
          n_d     = mem_q[top_idx_s];
          t_d     = bus.Result;
          depth_d = depth_q - DEPTH_ONE;
        end
`else
        n_d = mem_q[top_idx_s];
        t_d = bus.Result;
        if (empty_s) begin
          depth_d = DEPTH_LAST;
        end else begin
          depth_d = depth_q - DEPTH_ONE;
        end
`endif
      end
      CMD_REPLACE: begin
        t_d = bus.Result;
      end
      default: begin
        t_d = t_q;
      end
    endcase
  end

  // T, N and depth registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= {WIDTH{1'b0}};
      n_q     <= {WIDTH{1'b0}};
      depth_q <= {(PTRW+1){1'b0}};
    end else begin
      t_q     <= t_d;
      n_q     <= n_d;
      depth_q <= depth_d;
    end
  end

  // Spill array: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[free_idx_s] <= n_q;
    end
  end

  assign bus.T     = t_q;
  assign bus.N     = n_q;
  assign bus.depth = depth_q;

`ifdef DSTACK_GUARD_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky flags: clear first, a fresh error in the same cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.clrFlags) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      udf_d = udf_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else begin
      udf_d = udf_d;
    end
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  logic unused_s;
  assign unused_s      = ovf_set_s | udf_set_s | bus.clrFlags;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack; covers the guarded or unguarded build per DSTACK_GUARD_EN.
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  localparam logic [1:0] HOLD    = 2'b00;
  localparam logic [1:0] PUSH    = 2'b01;
  localparam logic [1:0] POP     = 2'b10;
  localparam logic [1:0] REPLACE = 2'b11;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  data_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) bus ();

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] ctrl, input logic [15:0] res, input logic clr, input logic r);
    bus.stackCtrl = ctrl;
    bus.Result    = res;
    bus.clrFlags  = clr;
    rst           = r;
    @(posedge clk);
    #1;
    bus.stackCtrl = HOLD;
    bus.clrFlags  = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] t, input logic [15:0] n,
                             input logic [2:0] d, input logic ov, input logic ud);
    check({tag, ".T"}, 32'(bus.T), 32'(t));
    check({tag, ".N"}, 32'(bus.N), 32'(n));
    check({tag, ".depth"}, 32'(bus.depth), 32'(d));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(ov));
    check({tag, ".udf"}, 32'(bus.underflow), 32'(ud));
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.stackCtrl = HOLD;
    bus.Result    = 16'h0000;
    bus.clrFlags  = 1'b0;

    step(PUSH, 16'h7777, 1'b0, 1'b1);
    check_state("reset", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

    // T=0,N=0 initially; each push spills the old N.
    step(PUSH, 16'h0001, 1'b0, 1'b0);
    step(PUSH, 16'h0002, 1'b0, 1'b0);
    step(PUSH, 16'h0003, 1'b0, 1'b0);
    check_state("push3", 16'h0003, 16'h0002, 3'd3, 1'b0, 1'b0);

    step(POP, 16'h0005, 1'b0, 1'b0);
    check_state("pop5", 16'h0005, 16'h0001, 3'd2, 1'b0, 1'b0);
    step(POP, 16'h0007, 1'b0, 1'b0);
    check_state("pop7", 16'h0007, 16'h0000, 3'd1, 1'b0, 1'b0);
    step(REPLACE, 16'h8000, 1'b0, 1'b0);
    check_state("repl", 16'h8000, 16'h0000, 3'd1, 1'b0, 1'b0);
    step(HOLD, 16'h1234, 1'b0, 1'b0);
    check_state("hold", 16'h8000, 16'h0000, 3'd1, 1'b0, 1'b0);
    step(POP, 16'h0009, 1'b0, 1'b0);
    check_state("pop9", 16'h0009, 16'h0000, 3'd0, 1'b0, 1'b0);

`ifdef DSTACK_GUARD_EN
    step(POP, 16'hAAAA, 1'b1, 1'b0);
    check_state("udf_clr", 16'h0009, 16'h0000, 3'd0, 1'b0, 1'b1);
    step(HOLD, 16'h0000, 1'b1, 1'b0);
    check_state("udf_cleared", 16'h0009, 16'h0000, 3'd0, 1'b0, 1'b0);
    // mem becomes {0,9,1,2}
    for (int i = 1; i <= DEPTH; i++) step(PUSH, 16'(i), 1'b0, 1'b0);
    check_state("full", 16'h0004, 16'h0003, 3'd4, 1'b0, 1'b0);
    step(PUSH, 16'hBEEF, 1'b0, 1'b0);
    check_state("ovf", 16'h0004, 16'h0003, 3'd4, 1'b1, 1'b0);
    step(PUSH, 16'h1111, 1'b1, 1'b0);
    check_state("ovf_clr", 16'h0004, 16'h0003, 3'd4, 1'b1, 1'b0);
    step(HOLD, 16'h0000, 1'b1, 1'b0);
    check_state("ovf_cleared", 16'h0004, 16'h0003, 3'd4, 1'b0, 1'b0);
    step(POP, 16'h0050, 1'b0, 1'b0);
    check_state("pop_full", 16'h0050, 16'h0002, 3'd3, 1'b0, 1'b0);
    step(REPLACE, 16'h8000, 1'b0, 1'b0);
    check_state("repl_d3", 16'h8000, 16'h0002, 3'd3, 1'b0, 1'b0);
    step(POP, 16'h0060, 1'b0, 1'b0);
    check_state("pop_d2", 16'h0060, 16'h0001, 3'd2, 1'b0, 1'b0);
    step(POP, 16'h0000, 1'b0, 1'b0);
    step(POP, 16'h0000, 1'b0, 1'b0);
    step(POP, 16'h0000, 1'b0, 1'b0);
    check_state("udf_again", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
`else
    // mem becomes {0,9,1,2}; the fifth push wraps and overwrites mem[0] with 3.
    for (int i = 1; i <= DEPTH; i++) step(PUSH, 16'(i), 1'b0, 1'b0);
    check_state("full", 16'h0004, 16'h0003, 3'd4, 1'b0, 1'b0);
    step(PUSH, 16'h0005, 1'b1, 1'b0);
    check_state("wrap_push", 16'h0005, 16'h0004, 3'd0, 1'b0, 1'b0);
    step(POP, 16'h0006, 1'b0, 1'b0);
    check_state("wrap_pop", 16'h0006, 16'h0002, 3'd3, 1'b0, 1'b0);
    step(POP, 16'h0007, 1'b0, 1'b0);
    check_state("pop_d2", 16'h0007, 16'h0001, 3'd2, 1'b0, 1'b0);
    step(POP, 16'h0008, 1'b0, 1'b0);
    check_state("pop_d1", 16'h0008, 16'h0009, 3'd1, 1'b0, 1'b0);
    step(POP, 16'h000A, 1'b0, 1'b0);
    check_state("pop_mem0", 16'h000A, 16'h0003, 3'd0, 1'b0, 1'b0);
`endif

    step(PUSH, 16'h4321, 1'b0, 1'b1);
    check_state("rst_push", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
